traffic_light_fsm: RTL

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

---
 rtl/traffic_light_fsm.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/traffic_light_fsm.sv
// Traffic light sequencer: IDLE -> GREEN -> YELLOW -> RED -> GREEN ... with per-phase countdown.
// Optional pedestrian-request shortening of GREEN is compiled in with `define PED_REQ_EN.
module traffic_light_fsm #(
    parameter int TIME_W    = 4,
    parameter int MIN_GREEN = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [TIME_W-1:0] red_time,
    input  logic [TIME_W-1:0] yellow_time,
    input  logic [TIME_W-1:0] green_time,
    input  logic              enable,
`ifdef PED_REQ_EN
    input  logic              ped_req,
    output logic              ped_pend,
`endif
    output logic              red_on,
    output logic              yellow_on,
    output logic              green_on,
    output logic [1:0]        state,
    output logic [TIME_W-1:0] count_rem,
    output logic              phase_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_RED    = 2'b11
    } phase_t;

    localparam logic [TIME_W-1:0] ZERO = '0;
    localparam logic [TIME_W-1:0] ONE  = TIME_W'(1);

    // MIN_GREEN has to be representable in count_rem; the block only exists to flag misuse in elaboration logs.
    if (MIN_GREEN < 0 || MIN_GREEN >= (1 << TIME_W)) begin : g_min_green_out_of_range
    end

    phase_t            state_reg, state_next;
    logic [TIME_W-1:0] count_reg, count_next;
    logic              phase_done_reg, phase_done_next;
    phase_t            succ_phase;
    logic [TIME_W-1:0] succ_load;
    logic [TIME_W-1:0] green_load;

    // A phase of time T lasts max(T,1) cycles, so the counter starts at T-1 saturated at zero.
    function automatic logic [TIME_W-1:0] phase_load(input logic [TIME_W-1:0] t);
        return (t == ZERO) ? ZERO : t - ONE;
    endfunction

    assign green_load = phase_load(green_time);

    always_comb begin
        succ_phase = ST_GREEN;
        succ_load  = green_load;
        case (state_reg)
            ST_GREEN: begin
                succ_phase = ST_YELLOW;
                succ_load  = phase_load(yellow_time);
            end
            ST_YELLOW: begin
                succ_phase = ST_RED;
                succ_load  = phase_load(red_time);
            end
            default: begin
                succ_phase = ST_GREEN;
                succ_load  = green_load;
            end
        endcase
    end

`ifdef PED_REQ_EN
    localparam logic [TIME_W-1:0] MIN_GREEN_T = TIME_W'(MIN_GREEN);

    logic ped_pend_reg, ped_pend_next;
    logic pend_now;

    // A request seen outside GREEN counts immediately, even on the edge that enters GREEN.
    assign pend_now = ped_pend_reg | (ped_req && (state_reg != ST_GREEN));
`endif

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        phase_done_next = 1'b0;
`ifdef PED_REQ_EN
        ped_pend_next   = ped_pend_reg;
`endif
        if (enable) begin
            if (state_reg == ST_IDLE) begin
                state_next = ST_GREEN;
                count_next = green_load;
            end else if (count_reg != ZERO) begin
                count_next = count_reg - ONE;
            end else begin
                state_next      = succ_phase;
                count_next      = succ_load;
                phase_done_next = 1'b1;
            end
`ifdef PED_REQ_EN
            if (state_reg == ST_GREEN) begin
                if (ped_req && (count_reg > MIN_GREEN_T)) begin
                    count_next = MIN_GREEN_T;
                end
            end else begin
                ped_pend_next = pend_now;
                if (state_next == ST_GREEN && pend_now) begin
                    ped_pend_next = 1'b0;
                    if (green_load > MIN_GREEN_T) begin
                        count_next = MIN_GREEN_T;
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_reg      <= ST_IDLE;
            count_reg      <= '0;
            phase_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            phase_done_reg <= phase_done_next;
        end
    end

`ifdef PED_REQ_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ped_pend_reg <= 1'b0;
        end else begin
            ped_pend_reg <= ped_pend_next;
        end
    end

    assign ped_pend = ped_pend_reg;
`endif

    // Lamps are a pure decode of the state register so they cannot glitch on input changes.
    assign green_on   = (state_reg == ST_GREEN);
    assign yellow_on  = (state_reg == ST_YELLOW);
    assign red_on     = (state_reg == ST_RED) || (state_reg == ST_IDLE);
    assign state      = state_reg;
    assign count_rem  = count_reg;
    assign phase_done = phase_done_reg;

endmodule
